sample_mixer: RTL
=================

# sample_mixer

Parametrised, sequential successor to the drum-voice summer. Mixes `NUM_CH` signed sample channels into one output sample per frame. Each channel has a per-channel enable and a gain, and the output saturates instead of wrapping. Sits between the per-voice sample players and the codec serialiser. The block captures inputs on the codec's per-frame `sample_req` pulse, then accumulates one channel per clock, so a single multiplier is shared across all channels.

## Interface
- `NUM_CH`, 7: number of input channels (≥1).
- `SAMPLE_W`, 16: sample width, signed two's complement.
- `GAIN_W`, 4: unsigned gain width; unity gain = 2^(GAIN_W-1).
- `CLK` in 1: single system clock.
- `Reset` in 1: synchronous, active-high.
- `poweron` in 1: low forces silence and aborts any frame in progress.
- `sample_req` in 1: one-cycle pulse requesting the next mixed sample.
- `select` in NUM_CH: bit i enables channel i.
- `samples` in NUM_CH*SAMPLE_W: channel i at `[i*SAMPLE_W +: SAMPLE_W]`, signed.
- `gain` in NUM_CH*GAIN_W: channel i at `[i*GAIN_W +: GAIN_W]`, unsigned.
- `dout` out SAMPLE_W: mixed sample, signed; holds its value between frames.
- `dout_valid` out 1: one-cycle pulse when `dout` updates.
- `clip` out 1: valid only with `dout_valid`; 1 if that sample saturated.
- `busy` out 1: high while a frame is in progress.
- `overrun` out 1: one-cycle pulse when `sample_req` arrives while busy.

## Operation
- States: IDLE, ACCUM, SAT.
- IDLE:
  - On `sample_req`=1 with `poweron`=1, snapshot `select`, `samples` and `gain` into internal registers.
  - Clear the accumulator, set channel index to 0, go to ACCUM.
- ACCUM:
  - Each cycle, for channel `ch`: if `select[ch]`, add `(sample * gain) >>> (GAIN_W-1)` to the accumulator.
  - `gain` is zero-extended. The shift is arithmetic, so products round toward −∞.
  - Disabled channels add 0.
  - After `ch` = NUM_CH-1, go to SAT.
- SAT:
  - Clamp the accumulator to [−2^(SAMPLE_W-1), 2^(SAMPLE_W-1)−1] and register it into `dout`.
  - Set `clip` if the clamp changed the value. Pulse `dout_valid`. Return to IDLE.
- Accumulator width ACC_W = SAMPLE_W + GAIN_W + clog2(NUM_CH), which makes internal overflow impossible.
- `sample_req` while busy: ignored, `overrun` pulses the next cycle, and the current frame is unaffected.
- `sample_req` in the same cycle SAT completes: ignored, with `overrun` (back-to-back frames are not supported).
- `poweron`=0 in any state:
  - Next cycle: state IDLE, `dout`=0, `busy`=0, no `dout_valid`.
  - Requests are ignored while low, and do not raise `overrun`.
- Reset values: state IDLE, `dout`=0, `dout_valid`=0, `clip`=0, `busy`=0, `overrun`=0; accumulator and index cleared.
- Reset mid-frame: abort with no output pulse.

## Timing
- `sample_req` sampled high at edge T → ACCUM occupies cycles T+1 … T+NUM_CH → SAT in cycle T+NUM_CH+1.
- `dout`, `dout_valid` and `clip` are visible from edge T+NUM_CH+2. Latency is NUM_CH+2 cycles (9 for the default).
- `busy` is high from T+1 through the SAT cycle.
- Minimum request spacing: NUM_CH+2 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `mixer_pkg`:
  - `mix_state_t` enum (IDLE, ACCUM, SAT).
  - Function `acc_width(SAMPLE_W, GAIN_W, NUM_CH)`.
  - Function `sat_to_sample` (clamp, returning value and clip flag).
- Sub-module `mix_mac`: one signed×unsigned multiply, arithmetic shift and enable-gated accumulate, with clear and step inputs.
- The FSM, snapshot registers and channel-index counter live in `sample_mixer`.

## Test plan
Defaults NUM_CH=7, SAMPLE_W=16, GAIN_W=4; all gains 8 unless stated.
- Reset high for 2 cycles → all outputs 0, `busy`=0. Then `sample_req` with `select`=0 → `dout_valid` at T+9, `dout`=0, `clip`=0.
- ch0=1000, ch6=−200, `select`=7'b1000001, one req → `dout`=800 at exactly T+9, `clip`=0, `busy` high T+1…T+8.
- ch1=4096 only:
  - gain 4 → 2048.
  - gain 15 → 7680.
  - gain 0 → 0.
  - ch1=−3, gain 1 → −1 (floor rounding).
- ch0..ch2=30000, `select`=7'b0000111 → 32767, `clip`=1. Negate all three → −32768, `clip`=1.
- Req at T and T+3 → single `dout_valid` at T+9; `overrun` pulse visible at T+4.
- `poweron` dropped at T+4 → no `dout_valid`, `dout`=0 by T+5, `busy`=0. Repeat with `Reset` at T+4 → identical result.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared types and helpers for the sample mixer: FSM state encoding,
// accumulator sizing and output saturation.
package mixer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mix_state_t;

    // Widest accumulator the saturation helper accepts.
    localparam int SAT_IN_W = 64;

    typedef struct packed {
        logic signed [SAT_IN_W-1:0] value;
        logic                       clip;
    } sat_result_t;

    // Accumulator width that cannot overflow: one full-scale scaled product
    // per channel, with headroom for NUM_CH of them.
    function automatic int acc_width(input int sample_w, input int gain_w, input int num_ch);
        return sample_w + gain_w + $clog2(num_ch);
    endfunction

    // Clamp a wide signed value to the signed sample_w-bit range; clip is set
    // when the clamp changed the value.
    function automatic sat_result_t sat_to_sample(input logic signed [SAT_IN_W-1:0] acc,
                                                  input int sample_w);
        logic signed [SAT_IN_W-1:0] max_v;
        logic signed [SAT_IN_W-1:0] min_v;
        sat_result_t                r;
        max_v = (64'sd1 <<< (sample_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (acc > max_v) begin
            r.value = max_v;
            r.clip  = 1'b1;
        end else if (acc < min_v) begin
            r.value = min_v;
            r.clip  = 1'b1;
        end else begin
            r.value = acc;
            r.clip  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mix_mac.sv
// Shared multiply-accumulate: one signed sample times an unsigned gain,
// scaled so that gain 2^(GAIN_W-1) is unity, added into the accumulator.
module mix_mac #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 4,
    parameter int ACC_W    = 23
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       clear,
    input  logic                       step,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [GAIN_W-1:0]   gain,
    output logic signed [ACC_W-1:0]    acc
);

    // One extra bit so the zero-extended gain stays positive as a signed operand.
    localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] scaled;
    logic signed [ACC_W-1:0]  term;

    // Scaled product of the current channel; arithmetic shift floors toward -inf.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a value on
        // every path, so no latch is inferred.
        sample_ext = PROD_W'(sample);
        gain_ext   = $signed(PROD_W'(gain));
        product    = sample_ext * gain_ext;
        scaled     = product >>> (GAIN_W - 1);
        term       = enable ? ACC_W'(scaled) : '0;
    end

    // Accumulator: cleared at frame start, adds one channel term per step.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (Reset || clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc + term;
        end
    end

endmodule

// File: rtl/sample_mixer.sv
// Frame-based sample mixer: snapshots NUM_CH channels on sample_req, runs
// them through one shared MAC, one channel per clock, then saturates into dout.
module sample_mixer
    import mixer_pkg::*;
#(
    parameter int NUM_CH   = 7,
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 4
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         poweron,
    input  logic                         sample_req,
    input  logic [NUM_CH-1:0]            select,
    input  logic [NUM_CH*SAMPLE_W-1:0]   samples,
    input  logic [NUM_CH*GAIN_W-1:0]     gain,
    output logic signed [SAMPLE_W-1:0]   dout,
    output logic                         dout_valid,
    output logic                         clip,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W = acc_width(SAMPLE_W, GAIN_W, NUM_CH);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    mix_state_t state;
    mix_state_t next_state;

    logic [CH_W-1:0]          ch_idx;
    logic [NUM_CH-1:0]        sel_q;
    logic [NUM_CH*SAMPLE_W-1:0] samples_q;
    logic [NUM_CH*GAIN_W-1:0] gain_q;

    logic                       capture;
    logic                       mac_clear;
    logic                       mac_step;
    logic                       finish;
    logic signed [SAMPLE_W-1:0] cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic                       cur_en;
    logic signed [ACC_W-1:0]    acc;
    sat_result_t                sat_res;

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and per-cycle control; power-down overrides everything.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        mac_clear  = 1'b0;
        mac_step   = 1'b0;
        finish     = 1'b0;
        if (!poweron) begin
            next_state = IDLE;
            mac_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_req) begin
                        next_state = ACCUM;
                        capture    = 1'b1;
                        mac_clear  = 1'b1;
                    end
                end
                ACCUM: begin
                    mac_step = 1'b1;
                    if (ch_idx == LAST_CH) begin
                        next_state = SAT;
                    end
                end
                SAT: begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Channel index: restarts at each capture, advances once per MAC step.
    always_ff @(posedge CLK) begin
        if (Reset || capture || !poweron) begin
            ch_idx <= '0;
        end else if (mac_step) begin
            ch_idx <= ch_idx + 1'b1;
        end
    end

    // Input snapshot so the frame is immune to input changes mid-accumulation.
    always_ff @(posedge CLK) begin
        // NOTE: pure datapath registers are not reset; they are always loaded
        // by a capture before anything reads them.
        if (capture) begin
            sel_q     <= select;
            samples_q <= samples;
            gain_q    <= gain;
        end
    end

    // Select the current channel's operands from the snapshot.
    always_comb begin
        cur_sample = '0;
        cur_gain   = '0;
        cur_en     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
                cur_sample = $signed(samples_q[i*SAMPLE_W +: SAMPLE_W]);
                cur_gain   = gain_q[i*GAIN_W +: GAIN_W];
                cur_en     = sel_q[i];
            end
        end
    end

    mix_mac #(
        .SAMPLE_W (SAMPLE_W),
        .GAIN_W   (GAIN_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .CLK    (CLK),
        .Reset  (Reset),
        .clear  (mac_clear),
        .step   (mac_step),
        .enable (cur_en),
        .sample (cur_sample),
        .gain   (cur_gain),
        .acc    (acc)
    );

    // Clamp the finished accumulator to the sample range.
    always_comb begin
        sat_res = sat_to_sample(SAT_IN_W'(acc), SAMPLE_W);
    end

    // Registered outputs: result/flag pulses, busy and overrun detection.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            clip       <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= finish;
            clip       <= finish & sat_res.clip;
            busy       <= (next_state != IDLE);
            overrun    <= poweron & sample_req & (state != IDLE);
            if (!poweron) begin
                dout <= '0;
            end else if (finish) begin
                dout <= sat_res.value[SAMPLE_W-1:0];
            end
        end
    end

endmodule
